// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, CPU_RD = 1'b1} state_t;
  localparam int EXT_WAIT_MAX_DEF = 4;
  localparam int WAIT_CNT_W       = 4;
endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating refusal counter for the external master; present only with
// DMEM_ARB_STARVE_GUARD_EN defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_wait_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX = EXT_WAIT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam logic [WAIT_CNT_W-1:0] MAX_C = WAIT_CNT_W'(MAX);

  logic [WAIT_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (inc && cnt != MAX_C) cnt <= cnt + 1'b1;
  end

  assign sat = (cnt == MAX_C);
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU MEM stage and an external
// master. Define DMEM_ARB_STARVE_GUARD_EN to enable the external anti-starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int EXT_WAIT_MAX = EXT_WAIT_MAX_DEF,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  if (EXT_WAIT_MAX < 1 || EXT_WAIT_MAX > 15) begin : g_bad_wait_max
    $error("EXT_WAIT_MAX out of range 1..15");
  end

  state_t state;
  logic   cpu_gnt, ext_gnt_i, ext_pri;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_wait_cnt #(.MAX(EXT_WAIT_MAX)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ext_req && !ext_gnt_i),
    .clr (ext_gnt_i),
    .sat (ext_pri)
  );
`else
  assign ext_pri = 1'b0;
`endif

  // CPU_RD leaves the port free for the external master; in IDLE the CPU
  // wins unless the starved external master has reached its wait limit.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt_i = 1'b0;
    if (rst) begin
      if (state == CPU_RD)                    ext_gnt_i = ext_req;
      else if (cpu_req && !(ext_req && ext_pri)) cpu_gnt = 1'b1;
      else                                    ext_gnt_i = ext_req;
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | ext_gnt_i;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_gnt_i) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Only a granted store completes without a hold; loads and refusals stall.
  assign cpu_stall = rst && (state == IDLE) && cpu_req && !(cpu_gnt && cpu_we);
  assign ext_gnt   = ext_gnt_i;
  assign cpu_rdata = (rst && state == CPU_RD) ? mem_rdata : '0;
  assign ext_rdata = (rst && ext_rvalid) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= ext_gnt_i && !ext_we;
      state      <= (state == IDLE && cpu_gnt && !cpu_we) ? CPU_RD : IDLE;
    end
  end
endmodule
